// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - funct3 operation codes (OP_MUL .. OP_REMU)
//   - FSM state encodings (S_IDLE, S_RUN, S_DONE)
//   - operation class predicates (is_div, is_signed_a, is_signed_b)
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // funct3[2] separates the divide/remainder group from the multiplies
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_prep.sv
// ---------------------------------------------------------------------------
// muldiv_sign_prep
// Combinational conditional two's-complement negate. Used at capture to turn
// signed operands into magnitudes, and at completion to apply the result sign.
// Ports:
//   val  in   WIDTH  input value
//   neg  in   1      1 = negate val, 0 = pass through
//   res  out  WIDTH  neg ? -val : val
// ---------------------------------------------------------------------------
module muldiv_sign_prep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    logic signed [WIDTH-1:0] val_s;
    logic signed [WIDTH-1:0] neg_s;

    assign val_s = $signed(val);
    assign neg_s = -val_s;
    assign res   = neg ? $unsigned(neg_s) : val;

endmodule

// File: rtl/muldiv_seq_unit.sv
// ---------------------------------------------------------------------------
// muldiv_seq_unit
// Iterative RV32M multiply/divide unit. One op per start pulse; radix-2
// shift-add multiply or restoring divide, one step per RUN cycle.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- when defined, divide by
// zero, signed divide overflow and multiply by zero skip RUN entirely.
// Ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   start      in   1           request, sampled only in IDLE
//   operation  in   3           funct3 (MUL..REMU)
//   a, b       in   DATA_WIDTH  rs1 / rs2 operands, captured with start
//   busy       out  1           high in RUN and DONE
//   done       out  1           one-cycle pulse, result valid
//   result     out  DATA_WIDTH  registered result
//   zero       out  1           result == 0
//   signBit    out  1           result MSB
// ---------------------------------------------------------------------------
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            operation,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  signBit
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   acc;      // mul: {partial high, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]     opnd;     // mul: |a| (multiplicand); div: |b| (divisor)
    logic [W-1:0]     a_r;      // original rs1, needed for REM by zero / DIV overflow
    logic [2:0]       op_r;
    logic             neg_r;
    logic             div_zero_r;
    logic             div_ovf_r;
    logic             mul_zero_r;
    logic             done_r;
    logic [W-1:0]     result_r;

    // Capture-side decode
    logic         sa, sb, cap_div, cap_bzero, cap_ovf, cap_mzero, cap_neg, cap_skip;
    logic [W-1:0] abs_a, abs_b;

    assign sa        = is_signed_a(operation) & a[W-1];
    assign sb        = is_signed_b(operation) & b[W-1];
    assign cap_div   = is_div(operation);
    assign cap_bzero = (b == '0);
    assign cap_ovf   = cap_div && is_signed_b(operation) &&
                       (a == {1'b1, {(W-1){1'b0}}}) && (&b);
    assign cap_mzero = !cap_div && ((a == '0) || (b == '0));
    // Remainder takes the dividend's sign; product and quotient take sa^sb
    assign cap_neg   = (cap_div && operation[1]) ? sa : (sa ^ sb);

`ifdef MULDIV_EARLY_OUT_EN
    assign cap_skip = cap_div ? (cap_bzero | cap_ovf) : cap_mzero;
`else
    assign cap_skip = 1'b0;
`endif

    muldiv_sign_prep #(.WIDTH(W)) u_abs_a (.val(a), .neg(sa), .res(abs_a));
    muldiv_sign_prep #(.WIDTH(W)) u_abs_b (.val(b), .neg(sb), .res(abs_b));

    // One multiply step: conditional add of the multiplicand into the high
    // half, then shift the whole accumulator right by one.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc[W-1:1]};

    // One restoring divide step: shift the next dividend bit into the
    // remainder, subtract when it fits, and shift the quotient bit in.
    logic [W:0]     div_sh, div_diff;
    logic           div_ge;
    logic [2*W-1:0] div_next;

    assign div_sh   = {acc[2*W-1:W], acc[W-1]};
    assign div_ge   = (div_sh >= {1'b0, opnd});
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_next = {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), acc[W-2:0], div_ge};

    // Completion: pick the raw field, apply the sign, then the forced cases
    logic [2*W-1:0] fin_raw, fin_fix;
    logic [W-1:0]   fin_res;

    always_comb begin
        fin_raw = acc;
        if (is_div(op_r))
            fin_raw = op_r[1] ? {{W{1'b0}}, acc[2*W-1:W]} : {{W{1'b0}}, acc[W-1:0]};
    end

    muldiv_sign_prep #(.WIDTH(2*W)) u_fix (.val(fin_raw), .neg(neg_r), .res(fin_fix));

    always_comb begin
        fin_res = fin_fix[W-1:0];
        if (is_div(op_r) && div_zero_r)
            fin_res = op_r[1] ? a_r : {W{1'b1}};
        else if (is_div(op_r) && div_ovf_r)
            fin_res = op_r[1] ? {W{1'b0}} : a_r;
        else if (!is_div(op_r) && mul_zero_r)
            fin_res = '0;
        else if (!is_div(op_r) && (op_r != OP_MUL))
            fin_res = fin_fix[2*W-1:W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            a_r        <= '0;
            op_r       <= OP_MUL;
            neg_r      <= 1'b0;
            div_zero_r <= 1'b0;
            div_ovf_r  <= 1'b0;
            mul_zero_r <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r       <= operation;
                        a_r        <= a;
                        neg_r      <= cap_neg;
                        div_zero_r <= cap_div & cap_bzero;
                        div_ovf_r  <= cap_ovf;
                        mul_zero_r <= cap_mzero;
                        opnd       <= cap_div ? abs_b : abs_a;
                        acc        <= {{W{1'b0}}, (cap_div ? abs_a : abs_b)};
                        cnt        <= CNT_W'(W);
                        state      <= cap_skip ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= is_div(op_r) ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    result_r <= fin_res;
                    done_r   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state == S_RUN) || (state == S_DONE);
    assign done    = done_r;
    assign result  = result_r;
    assign zero    = (result_r == '0);
    assign signBit = result_r[W-1];

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq_unit
// Directed-vector bench for muldiv_seq_unit with a queue-based scoreboard:
// the stimulus process pushes hand-computed expected results, a monitor
// process pops and compares them whenever done pulses.
// ---------------------------------------------------------------------------
module tb_muldiv_seq_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int FULL_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  operation = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero, signBit;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    muldiv_seq_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zero(zero), .signBit(signBit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk({nm, "_result"}, result, e);
                    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, (e == 32'd0)});
                    chk({nm, "_sign"}, {31'd0, signBit}, {31'd0, e[31]});
                end
            end
        end
    end

    // Issue one op, measure edges from the start edge to done, optionally
    // poke start with different operands while the unit is busy.
    task automatic do_op(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] req, input string nm, input int lat, input bit poke);
        int n;
        exp_q.push_back(req);
        name_q.push_back(nm);
        @(negedge clk);
        operation = op; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 3) begin
                start = 1'b1; operation = DIVU; a = 32'd1000; b = 32'd7;
            end
            if (poke && n == 4) start = 1'b0;
            if (poke && n == 10) chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        end while (!done && n < 200);
        if (n >= 200) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else          chk({nm, "_latency"}, n, lat);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_sign", {31'd0, signBit}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3",      FULL_LAT, 1'b0);
        do_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max",    FULL_LAT, 1'b0);
        do_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1",   FULL_LAT, 1'b0);
        do_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1",    FULL_LAT, 1'b0);
        do_op(MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_wrap",     FULL_LAT, 1'b0);
        do_op(DIV,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, "div_m20_3",    FULL_LAT, 1'b0);
        do_op(REM,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, "rem_m20_3",    FULL_LAT, 1'b0);
        do_op(DIV,    32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, "div_20_m3",     FULL_LAT, 1'b0);
        do_op(REM,    32'd20,       32'hFFFF_FFFD, 32'd2,         "rem_20_m3",     FULL_LAT, 1'b0);
        do_op(REMU,   32'd20,       32'd3,         32'd2,         "remu_20_3",     FULL_LAT, 1'b0);
        do_op(DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, "divu_max_1",    FULL_LAT, 1'b0);
        do_op(DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, "div_by0",       EO_LAT,   1'b0);
        do_op(DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, "divu_by0",      EO_LAT,   1'b0);
        do_op(REM,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, "rem_by0",       EO_LAT,   1'b0);
        do_op(REMU,   32'd5,        32'd0,         32'd5,         "remu_by0",      EO_LAT,   1'b0);
        do_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",     EO_LAT,   1'b0);
        do_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf",     EO_LAT,   1'b0);
        do_op(MUL,    32'd0,        32'h1234_5678, 32'd0,         "mul_a0",        EO_LAT,   1'b0);
        do_op(MUL,    32'd123,      32'd45,        32'd5535,      "mul_poke",      FULL_LAT, 1'b1);
        do_op(DIVU,   32'd20,       32'd3,         32'd6,         "divu_20_3",     FULL_LAT, 1'b0);

        // Abort mid-RUN: no done may follow and the result register clears
        @(negedge clk);
        operation = MUL; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        chk("pending_expectations", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
